// File: rtl/regfile_wb_pkg.sv
// Shared parameters and types for the register-file write-back controller.
//   ADDR_W       : register address width
//   DATA_W       : register data width
//   FIFO_DEPTH   : number of multi-cycle results that can wait for a write slot
//   STARVE_LIMIT : stalled cycles with a waiting result before pipe_hold is raised
package regfile_wb_pkg;

  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;
  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  localparam int NREGS    = 1 << ADDR_W;
  localparam int ENTRY_W  = ADDR_W + DATA_W;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  // One buffered multi-cycle result.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Source chosen for the write port in the current cycle.
  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_FIFO = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with valid/ready on both sides.
//   clk, rst             : clock, synchronous active-high reset (empties FIFO)
//   in_valid/in_ready    : push side; in_data captured when both high
//   in_data              : entry to store
//   out_valid/out_ready  : pop side; head removed when both high
//   out_data             : current head entry
// Handshake: a transfer happens on a rising clk edge when valid && ready on
// that side. in_ready is "not full" before any same-cycle pop, so a full FIFO
// never accepts in the cycle it is being popped.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Arbitrates the single register-file write port between the pipeline
// write-back and buffered multi-cycle results, and tracks registers that
// still await a multi-cycle result (scoreboard) for decode hazard checks.
//   clk, rst                      : clock, synchronous active-high reset
//   pipe_wb_valid/addr/data       : pipeline write-back, highest priority
//   mc_valid/mc_ready/addr/data   : multi-cycle results, buffered in a FIFO
//   issue_valid/issue_addr        : marks a register as pending
//   rs_addr/rt_addr -> *_busy     : pending-result query for decode
//   pipe_hold                     : ask the pipeline to leave a free slot
//   w_ena/w_addr/w_data           : registered register-file write port
// Handshake: an mc result transfers on a rising clk edge when
// mc_valid && mc_ready; mc_ready is high whenever the FIFO is not full.
module regfile_wb_ctrl
  import regfile_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_valid,
  input  logic [ADDR_W-1:0] pipe_wb_addr,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] mc_addr,
  input  logic [DATA_W-1:0] mc_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              pipe_hold,
  output logic              w_ena,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data
);

  wb_entry_t           fifo_in;
  wb_entry_t           fifo_head;
  logic                fifo_valid;
  logic                fifo_pop;
  wb_sel_e             sel;
  logic [NREGS-1:0]    scoreboard;
  logic [NREGS-1:0]    set_mask;
  logic [NREGS-1:0]    clr_mask;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_nxt;

  assign fifo_in = '{addr: mc_addr, data: mc_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mc_valid),
    .in_ready  (mc_ready),
    .in_data   (fifo_in),
    .out_valid (fifo_valid),
    .out_ready (!pipe_wb_valid),
    .out_data  (fifo_head)
  );

  always_comb begin
    sel = SEL_IDLE;
    if (pipe_wb_valid)   sel = SEL_PIPE;
    else if (fifo_valid) sel = SEL_FIFO;
  end

  assign fifo_pop = (sel == SEL_FIFO);

  // Write port. Address 0 is never written but a queued entry for it is
  // still consumed so it cannot block the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ena  <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      case (sel)
        SEL_PIPE: begin
          w_ena  <= (pipe_wb_addr != '0);
          w_addr <= pipe_wb_addr;
          w_data <= pipe_wb_data;
        end
        SEL_FIFO: begin
          w_ena  <= (fifo_head.addr != '0);
          w_addr <= fifo_head.addr;
          w_data <= fifo_head.data;
        end
        default: w_ena <= 1'b0;
      endcase
    end
  end

  // Clear is applied before set so a re-issue to the register being
  // retired in the same cycle stays pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_addr != '0)) set_mask[issue_addr] = 1'b1;
    if (fifo_pop) clr_mask[fifo_head.addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) scoreboard <= '0;
    else     scoreboard <= (scoreboard & ~clr_mask) | set_mask;
  end

  assign rs_busy = (rs_addr != '0) && scoreboard[rs_addr];
  assign rt_busy = (rt_addr != '0) && scoreboard[rt_addr];

  // Starvation counter saturates at the limit; any pop or an empty FIFO
  // ends the run of stalled cycles.
  always_comb begin
    starve_nxt = '0;
    if (!fifo_pop && fifo_valid) begin
      if (starve_cnt == STARVE_W'(STARVE_LIMIT)) starve_nxt = starve_cnt;
      else                                       starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      pipe_hold  <= (starve_nxt == STARVE_W'(STARVE_LIMIT));
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
  import regfile_wb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_wb_valid;
  logic [ADDR_W-1:0] pipe_wb_addr;
  logic [DATA_W-1:0] pipe_wb_data;
  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_busy;
  logic              rt_busy;
  logic              pipe_hold;
  logic              w_ena;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  regfile_wb_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_wb_addr  (pipe_wb_addr),
    .pipe_wb_data  (pipe_wb_data),
    .mc_valid      (mc_valid),
    .mc_ready      (mc_ready),
    .mc_addr       (mc_addr),
    .mc_data       (mc_data),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_busy       (rs_busy),
    .rt_busy       (rt_busy),
    .pipe_hold     (pipe_hold),
    .w_ena         (w_ena),
    .w_addr        (w_addr),
    .w_data        (w_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model state
  logic [ENTRY_W-1:0] exp_q[$];
  bit                 sb_model [NREGS];
  int                 stall_run;
  logic               ew_ena;
  logic [ADDR_W-1:0]  ew_addr;
  logic [DATA_W-1:0]  ew_data;
  logic               ehold;
  logic               last_acc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    foreach (sb_model[i]) sb_model[i] = 1'b0;
    stall_run = 0;
    ew_ena    = 1'b0;
    ew_addr   = '0;
    ew_data   = '0;
    ehold     = 1'b0;
    last_acc  = 1'b0;
  endtask

  task automatic idle_inputs();
    pipe_wb_valid = 1'b0; pipe_wb_addr = '0; pipe_wb_data = '0;
    mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
    rs_addr = '0; rt_addr = '0;
  endtask

  // One clock cycle with the inputs currently driven: check combinational
  // outputs, advance the model, then check registered outputs after the edge.
  task automatic tick();
    int          had;
    logic        pop;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  haddr;
    #1;
    check("mc_ready", mc_ready, exp_q.size() < FIFO_DEPTH);
    check("rs_busy", rs_busy, (rs_addr != 0) && sb_model[rs_addr]);
    check("rt_busy", rt_busy, (rt_addr != 0) && sb_model[rt_addr]);
    if (rst) begin
      model_reset();
    end else begin
      had      = exp_q.size();
      last_acc = mc_valid && (had < FIFO_DEPTH);
      pop      = !pipe_wb_valid && (had > 0);
      if (pipe_wb_valid) begin
        ew_ena = (pipe_wb_addr != 0); ew_addr = pipe_wb_addr; ew_data = pipe_wb_data;
      end else if (pop) begin
        head  = exp_q.pop_front();
        haddr = head[ENTRY_W-1 -: ADDR_W];
        ew_ena = (haddr != 0); ew_addr = haddr; ew_data = head[DATA_W-1:0];
        sb_model[haddr] = 1'b0;
      end else begin
        ew_ena = 1'b0;
      end
      if (issue_valid && issue_addr != 0) sb_model[issue_addr] = 1'b1;
      if (last_acc) exp_q.push_back({mc_addr, mc_data});
      if (pop)          stall_run = 0;
      else if (had > 0) stall_run++;
      else              stall_run = 0;
      ehold = (stall_run >= STARVE_LIMIT);
    end
    @(posedge clk);
    #1;
    check("w_ena", w_ena, ew_ena);
    check("w_addr", w_addr, ew_addr);
    check("w_data", w_data, ew_data);
    check("pipe_hold", pipe_hold, ehold);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_w_ena", w_ena, 1'b0);
    check("rst_w_data", w_data, 32'h0);
    check("rst_mc_ready", mc_ready, 1'b1);
    check("rst_hold", pipe_hold, 1'b0);
    tick();
    rst = 1'b0;

    // Pipeline write lands one cycle later.
    pipe_wb_valid = 1'b1; pipe_wb_addr = 5'd5; pipe_wb_data = 32'h12345678;
    tick();
    check("pipe_w_ena", w_ena, 1'b1);
    check("pipe_w_addr", w_addr, 5'd5);
    check("pipe_w_data", w_data, 32'h12345678);
    idle_inputs();
    tick();
    check("idle_hold_data", w_data, 32'h12345678);

    // Issue, then result; busy until the result reaches the write port.
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    idle_inputs();
    rs_addr = 5'd9;
    mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'hDEADBEEF;
    tick();
    check("busy_pending", rs_busy, 1'b1);
    mc_valid = 1'b0;
    tick();
    check("mc_w_addr", w_addr, 5'd9);
    check("mc_w_data", w_data, 32'hDEADBEEF);
    check("busy_cleared", rs_busy, 1'b0);
    idle_inputs();

    // One queued entry starved by six pipeline writes.
    mc_valid = 1'b1; mc_addr = 5'd3; mc_data = 32'hA5A5_0003;
    for (int i = 0; i < 6; i++) begin
      pipe_wb_valid = 1'b1; pipe_wb_addr = 5'(i + 20); pipe_wb_data = 32'(i);
      tick();
      mc_valid = 1'b0;
    end
    check("starve_hold", pipe_hold, 1'b1);
    idle_inputs();
    tick();
    check("starve_drain_addr", w_addr, 5'd3);
    check("starve_drain_ena", w_ena, 1'b1);
    tick();
    check("starve_hold_off", pipe_hold, 1'b0);

    // Three back-to-back results against a busy pipeline.
    for (int i = 0; i < 3; i++) begin
      pipe_wb_valid = 1'b1; pipe_wb_addr = 5'd1; pipe_wb_data = 32'(100 + i);
      mc_valid = 1'b1; mc_addr = 5'(10 + i); mc_data = 32'(200 + i);
      tick();
    end
    check("full_ready", mc_ready, 1'b0);
    pipe_wb_valid = 1'b0;
    tick();
    tick();
    mc_valid = 1'b0;
    tick();
    check("drain_third", w_addr, 5'd12);
    check("drain_third_data", w_data, 32'd202);
    tick();

    // Address zero is never written or marked busy.
    pipe_wb_valid = 1'b1; pipe_wb_addr = 5'd0; pipe_wb_data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_addr = 5'd0;
    tick();
    check("zero_w_ena", w_ena, 1'b0);
    check("zero_busy", rs_busy, 1'b0);
    idle_inputs();

    // Reset with a full FIFO and pending registers.
    for (int i = 0; i < 2; i++) begin
      pipe_wb_valid = 1'b1; pipe_wb_addr = 5'd2; pipe_wb_data = 32'(i);
      mc_valid = 1'b1; mc_addr = 5'(4 + i); mc_data = 32'(300 + i);
      issue_valid = 1'b1; issue_addr = 5'(4 + 3 * i);
      tick();
    end
    idle_inputs();
    rst = 1'b1; rs_addr = 5'd4; rt_addr = 5'd7;
    tick();
    check("rst_full_ready", mc_ready, 1'b1);
    check("rst_rs_busy", rs_busy, 1'b0);
    check("rst_rt_busy", rt_busy, 1'b0);
    check("rst_full_w_ena", w_ena, 1'b0);
    rst = 1'b0;
    repeat (3) tick();

    // Randomized traffic; the mc source holds its request until accepted.
    last_acc = 1'b0;
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      pipe_wb_valid = ($urandom_range(0, 99) < 55);
      pipe_wb_addr = 5'($urandom_range(0, 31));
      pipe_wb_data = $urandom;
      if (!(mc_valid && !last_acc)) begin
        mc_valid = ($urandom_range(0, 1) == 1);
        mc_addr  = 5'($urandom_range(0, 31));
        mc_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = 5'($urandom_range(0, 31));
      rs_addr = 5'($urandom_range(0, 31));
      rt_addr = 5'($urandom_range(0, 31));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
